// File: rtl/fb_writer_pkg.sv
// Types and defaults shared by the framebuffer write path and the SPI command decoder.
package fb_writer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEF_H_RES = 480;
  localparam int DEF_V_RES = 320;

  localparam int COORD_W = 16;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/fifo_window_writer_rise_pulse.sv
// Rising-edge detector: one history flop, output high for the first cycle a level is seen high.
module rise_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_reg <= 1'b0;
    else        level_reg <= level;
  end

  assign pulse = level & ~level_reg;

endmodule

// File: rtl/fifo_window_writer.sv
// Turns level write requests into single-cycle FIFO strobes, walking a CASET/RASET window
// and tagging each strobe with its pixel coordinate plus line/frame completion.
module fifo_window_writer
  import fb_writer_pkg::*;
#(
  parameter int X_W   = 11,
  parameter int Y_W   = 10,
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [COORD_W-1:0] i_start_x,
  input  logic [COORD_W-1:0] i_end_x,
  input  logic [COORD_W-1:0] i_start_y,
  input  logic [COORD_W-1:0] i_end_y,
  input  logic               i_win_set_req,
  input  logic               i_write_req,
  output logic               o_fifo_write,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic               o_line_done,
  output logic               o_frame_done,
  output logic               o_drop,
  output logic               o_win_err
);

  localparam logic [X_W:0] X_LIM = (X_W+1)'(H_RES);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(V_RES);

  logic win_edge;
  logic write_edge;

  rise_pulse u_win_edge (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .level (i_win_set_req),
    .pulse (win_edge)
  );

  rise_pulse u_write_edge (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .level (i_write_req),
    .pulse (write_edge)
  );

  logic [X_W-1:0] start_x_in, end_x_in;
  logic [Y_W-1:0] start_y_in, end_y_in;
  logic           win_valid;

  assign start_x_in = i_start_x[X_W-1:0];
  assign end_x_in   = i_end_x[X_W-1:0];
  assign start_y_in = i_start_y[Y_W-1:0];
  assign end_y_in   = i_end_y[Y_W-1:0];

  // Compare against the panel limits one bit wider so H_RES/V_RES == 2**W still works.
  assign win_valid = (start_x_in <= end_x_in) && ({1'b0, end_x_in} < X_LIM) &&
                     (start_y_in <= end_y_in) && ({1'b0, end_y_in} < Y_LIM);

  generate
    if (X_W < COORD_W) begin : g_unused_x
      logic unused_x_bits;
      assign unused_x_bits = ^{i_start_x[COORD_W-1:X_W], i_end_x[COORD_W-1:X_W]};
    end
    if (Y_W < COORD_W) begin : g_unused_y
      logic unused_y_bits;
      assign unused_y_bits = ^{i_start_y[COORD_W-1:Y_W], i_end_y[COORD_W-1:Y_W]};
    end
  endgenerate

  state_t         state_reg;
  logic [X_W-1:0] start_x_reg, end_x_reg, x_reg, x_out_reg;
  logic [Y_W-1:0] start_y_reg, end_y_reg, y_reg, y_out_reg;
  logic           fifo_write_reg, line_done_reg, frame_done_reg, drop_reg, win_err_reg;

  logic x_at_end, y_at_end;
  assign x_at_end = (x_reg == end_x_reg);
  assign y_at_end = (y_reg == end_y_reg);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      start_x_reg    <= '0;
      end_x_reg      <= '0;
      start_y_reg    <= '0;
      end_y_reg      <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      x_out_reg      <= '0;
      y_out_reg      <= '0;
      fifo_write_reg <= 1'b0;
      line_done_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      drop_reg       <= 1'b0;
      win_err_reg    <= 1'b0;
    end else begin
      fifo_write_reg <= 1'b0;
      line_done_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      drop_reg       <= 1'b0;
      if (win_edge) begin
        // A write arriving with the window set is discarded; the new window starts clean.
        start_x_reg <= start_x_in;
        end_x_reg   <= end_x_in;
        start_y_reg <= start_y_in;
        end_y_reg   <= end_y_in;
        x_reg       <= start_x_in;
        y_reg       <= start_y_in;
        drop_reg    <= write_edge;
        if (win_valid) begin
          state_reg   <= ACTIVE;
          win_err_reg <= 1'b0;
        end else begin
          state_reg   <= IDLE;
          win_err_reg <= 1'b1;
        end
      end else if (write_edge) begin
        case (state_reg)
          ACTIVE: begin
            fifo_write_reg <= 1'b1;
            x_out_reg      <= x_reg;
            y_out_reg      <= y_reg;
            if (!x_at_end) begin
              x_reg <= x_reg + 1'b1;
            end else begin
              x_reg         <= start_x_reg;
              line_done_reg <= 1'b1;
              if (!y_at_end) begin
                y_reg <= y_reg + 1'b1;
              end else begin
                y_reg          <= start_y_reg;
                frame_done_reg <= 1'b1;
              end
            end
          end
          default: drop_reg <= 1'b1;
        endcase
      end
    end
  end

  assign o_fifo_write = fifo_write_reg;
  assign o_x          = x_out_reg;
  assign o_y          = y_out_reg;
  assign o_line_done  = line_done_reg;
  assign o_frame_done = frame_done_reg;
  assign o_drop       = drop_reg;
  assign o_win_err    = win_err_reg;

endmodule

// File: tb/tb_fifo_window_writer.sv
// Bench for fifo_window_writer: directed vector table, held-request sequence, and random
// traffic checked against a pixel-index reference model.
module tb_fifo_window_writer;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int H_RES = 480;
  localparam int V_RES = 320;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [15:0]        start_x = '0, end_x = '0, start_y = '0, end_y = '0;
  logic               win_set_req = 1'b0, write_req = 1'b0;
  logic               fifo_write, line_done, frame_done, drop, win_err;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;

  always #5 clk = ~clk;

  fifo_window_writer #(.X_W(X_W), .Y_W(Y_W), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start_x     (start_x),
    .i_end_x       (end_x),
    .i_start_y     (start_y),
    .i_end_y       (end_y),
    .i_win_set_req (win_set_req),
    .i_write_req   (write_req),
    .o_fifo_write  (fifo_write),
    .o_x           (x),
    .o_y           (y),
    .o_line_done   (line_done),
    .o_frame_done  (frame_done),
    .o_drop        (drop),
    .o_win_err     (win_err)
  );

  typedef struct {
    bit fw, ld, fd, dr, err;
    int x, y;
  } out_t;

  typedef struct {
    bit   rst, win, wr;
    int   sx, ex, sy, ey;
    out_t exp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: window plus a count of pixels written since it was set.
  bit m_active = 0, m_err = 0;
  int m_sx, m_ex, m_sy, m_ey, m_n, m_ox = 0, m_oy = 0;

  function automatic void model_reset();
    m_active = 0; m_err = 0; m_ox = 0; m_oy = 0; m_n = 0;
  endfunction

  function automatic out_t model_step(bit win, bit wr, int sx, int ex, int sy, int ey);
    out_t o;
    int w, h, k;
    o.fw = 0; o.ld = 0; o.fd = 0; o.dr = 0;
    if (win) begin
      sx = sx % (1 << X_W); ex = ex % (1 << X_W);
      sy = sy % (1 << Y_W); ey = ey % (1 << Y_W);
      if (sx <= ex && ex < H_RES && sy <= ey && ey < V_RES) begin
        m_active = 1; m_err = 0;
        m_sx = sx; m_ex = ex; m_sy = sy; m_ey = ey; m_n = 0;
      end else begin
        m_active = 0; m_err = 1;
      end
      o.dr = wr;
    end else if (wr) begin
      if (!m_active) begin
        o.dr = 1;
      end else begin
        w = m_ex - m_sx + 1;
        h = m_ey - m_sy + 1;
        k = m_n % (w * h);
        m_ox = m_sx + k % w;
        m_oy = m_sy + k / w;
        o.fw = 1;
        o.ld = (k % w) == (w - 1);
        o.fd = k == (w * h - 1);
        m_n++;
      end
    end
    o.err = m_err; o.x = m_ox; o.y = m_oy;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.fw = fifo_write; o.ld = line_done; o.fd = frame_done; o.dr = drop; o.err = win_err;
    o.x = int'(x); o.y = int'(y);
    return o;
  endfunction

  task automatic compare(string name, out_t act, out_t exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act fw=%0b ld=%0b fd=%0b drop=%0b err=%0b x=%0d y=%0d req fw=%0b ld=%0b fd=%0b drop=%0b err=%0b x=%0d y=%0d",
               name, act.fw, act.ld, act.fd, act.dr, act.err, act.x, act.y,
               exp.fw, exp.ld, exp.fd, exp.dr, exp.err, exp.x, exp.y);
    end
  endtask

  function automatic out_t quiet_exp();
    out_t o;
    o.fw = 0; o.ld = 0; o.fd = 0; o.dr = 0; o.err = m_err; o.x = m_ox; o.y = m_oy;
    return o;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the event cycle and one idle cycle.
  task automatic apply(input bit win, input bit wr, input int sx, input int ex,
                       input int sy, input int ey, output out_t act, output out_t mexp);
    start_x = 16'(sx); end_x = 16'(ex); start_y = 16'(sy); end_y = 16'(ey);
    win_set_req = win; write_req = wr;
    mexp = model_step(win, wr, sx, ex, sy, ey);
    @(posedge clk); #1;
    act = sample();
    $display("txn win=%0b wr=%0b -> fw=%0b x=%0d y=%0d ld=%0b fd=%0b drop=%0b err=%0b",
             win, wr, act.fw, act.x, act.y, act.ld, act.fd, act.dr, act.err);
    win_set_req = 0; write_req = 0;
    @(posedge clk); #1;
    compare("idle_after_txn", sample(), quiet_exp());
  endtask

  task automatic do_reset();
    out_t z;
    rst_n = 0;
    model_reset();
    #1;
    z.fw = 0; z.ld = 0; z.fd = 0; z.dr = 0; z.err = 0; z.x = 0; z.y = 0;
    compare("reset_state", sample(), z);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(bit rst, bit win, bit wr, int sx, int ex, int sy, int ey,
                              bit fw, int ox, int oy, bit ld, bit fd, bit dr, bit err);
    vec_t v;
    v.rst = rst; v.win = win; v.wr = wr; v.sx = sx; v.ex = ex; v.sy = sy; v.ey = ey;
    v.exp.fw = fw; v.exp.x = ox; v.exp.y = oy; v.exp.ld = ld; v.exp.fd = fd;
    v.exp.dr = dr; v.exp.err = err;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    out_t act, mexp;
    int   strobes;
    int   sx, ex, sy, ey, r;
    bit   win, wr;

    //            rst win wr  sx       ex       sy       ey     fw  x    y   ld fd dr err
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      0, 0,   0,  0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      0, 0,   0,  0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 10,      12,      20,      21,     0, 0,   0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 10,  20, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 11,  20, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 12,  20, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 10,  21, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 11,  21, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 12,  21, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 10,  20, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,       480,     0,       10,     0, 10,  20, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      0, 10,  20, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 100,     103,     50,      52,     0, 10,  20, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,       5,       5,       4,      0, 10,  20, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      0, 10,  20, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 100,     103,     50,      52,     0, 10,  20, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 100, 50, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 200,     201,     30,      31,     0, 100, 50, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 200, 30, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 'h0803,  'h0805,  'h0401,  'h0401, 0, 200, 30, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 3,   1,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 7,       7,       7,       7,      0, 3,   1,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 7,   7,  1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,       0,       0,       0,      1, 7,   7,  1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,       0,       0,       0,      0, 0,   0,  0, 0, 1, 0));

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].win, tbl[i].wr, tbl[i].sx, tbl[i].ex, tbl[i].sy, tbl[i].ey, act, mexp);
      compare($sformatf("vec%0d", i), act, tbl[i].exp);
    end

    // Request held high for 10 cycles yields one strobe; the cursor moves by exactly one pixel.
    apply(1, 0, 40, 43, 60, 61, act, mexp);
    compare("held_win", act, mexp);
    write_req = 1;
    mexp = model_step(0, 1, 0, 0, 0, 0);
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      act = sample();
      if (act.fw) strobes++;
      if (c == 0) compare("held_first", act, mexp);
    end
    write_req = 0;
    @(posedge clk); #1;
    checks++;
    if (strobes != 1) begin
      failures++;
      $display("FAIL held_strobes act=%0d req=1", strobes);
    end
    $display("txn held 10 cycles -> strobes=%0d", strobes);
    apply(0, 1, 0, 0, 0, 0, act, mexp);
    compare("held_next", act, mexp);

    // Random traffic against the model.
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
        continue;
      end
      win = (r < 14);
      wr  = (r >= 8);
      sx = $urandom_range(0, 470);
      ex = sx + $urandom_range(0, 4);
      sy = $urandom_range(0, 310);
      ey = sy + $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        0: ex = $urandom_range(480, 2047);
        1: sy = ey + 1;
        2: begin sx = sx + 2048; ex = ex + 2048 * $urandom_range(1, 3); end
        default: ;
      endcase
      apply(win, wr, sx, ex, sy, ey, act, mexp);
      compare($sformatf("rand%0d", t), act, mexp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
